// File: rtl/alu_pkg.sv
// Shared ALU constants, pipeline register layouts and operand conditioning.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package alu_pkg;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;
    localparam int   XLEN   = 32;
    localparam int   HALF   = 16;

    // Stage A holds the finished low half plus the raw high operands.
    typedef struct packed {
        logic [HALF-1:0] lo_sum;
        logic            c16;
        logic            lo_zero;
        logic [HALF-1:0] hi_a;
        logic [HALF-1:0] hi_bx;
    } stage_a_t;

    // Stage B holds the complete result and its flags.
    typedef struct packed {
        logic [XLEN-1:0] sum;
        logic            c;
        logic            z;
        logic            n;
        logic            v;
    } result_t;

    // SUB is done as A + ~B + 1; the +1 enters as the low-half carry-in.
    function automatic logic [XLEN-1:0] cond_operand(input logic [XLEN-1:0] b, input logic op);
        return (op == OP_ADD) ? b : ~b;
    endfunction

endpackage

// File: rtl/addsub_pipe32_if.sv
// Issue-side and writeback-side handshake bundle for the add/sub stage.
// Latency: n/a (wires only).
// Backpressure: valid/ready on both the operand and the result side.
interface addsub_pipe32_if
    import alu_pkg::*;
#(
    parameter int TAG_W = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [XLEN-1:0]  in_a;
    logic [XLEN-1:0]  in_b;
    logic             in_op;
    logic [TAG_W-1:0] in_tag;

    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  out_sum;
    logic             out_c;
    logic             out_z;
    logic             out_n;
    logic             out_v;
    logic [TAG_W-1:0] out_tag;

    // Upstream issuer and downstream consumer side.
    modport master (
        output in_valid, in_a, in_b, in_op, in_tag, out_ready,
        input  in_ready, out_valid, out_sum, out_c, out_z, out_n, out_v, out_tag
    );

    // The execution stage itself.
    modport slave (
        input  in_valid, in_a, in_b, in_op, in_tag, out_ready,
        output in_ready, out_valid, out_sum, out_c, out_z, out_n, out_v, out_tag
    );
endinterface

// File: rtl/cla16.sv
// 16-bit carry-lookahead adder: four 4-bit groups under a second lookahead level.
// Latency: combinational.
// Backpressure: none.
module cla16 (
    input  logic [15:0] a_i,
    input  logic [15:0] b_i,
    input  logic        cin_i,
    output logic [15:0] sum_o,
    output logic        cout_o
);
    logic [15:0] g;
    logic [15:0] p;
    logic [15:0] c;
    logic [3:0]  gg;
    logic [3:0]  pg;
    logic [3:0]  gc;

    // Bit generate/propagate and the per-group generate/propagate terms.
    always_comb begin
        g  = a_i & b_i;
        p  = a_i ^ b_i;
        gg = '0;
        pg = '0;
        for (int k = 0; k < 4; k++) begin
            gg[k] = g[4*k+3]
                  | (p[4*k+3] & g[4*k+2])
                  | (p[4*k+3] & p[4*k+2] & g[4*k+1])
                  | ((&p[4*k+1 +: 3]) & g[4*k]);
            pg[k] = &p[4*k +: 4];
        end
    end

    // Second-level lookahead: group carry-ins and carry-out straight from cin.
    always_comb begin
        gc[0]  = cin_i;
        gc[1]  = gg[0] | (pg[0] & cin_i);
        gc[2]  = gg[1] | (pg[1] & gg[0]) | (pg[1] & pg[0] & cin_i);
        gc[3]  = gg[2] | (pg[2] & gg[1]) | (pg[2] & pg[1] & gg[0])
               | (pg[2] & pg[1] & pg[0] & cin_i);
        cout_o = gg[3] | (pg[3] & gg[2]) | (pg[3] & pg[2] & gg[1])
               | (pg[3] & pg[2] & pg[1] & gg[0]) | ((&pg) & cin_i);
    end

    // In-group carries from each group's carry-in, then the sum bits.
    always_comb begin
        c = '0;
        for (int k = 0; k < 4; k++) begin
            c[4*k]   = gc[k];
            c[4*k+1] = g[4*k] | (p[4*k] & gc[k]);
            c[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k]) | (p[4*k+1] & p[4*k] & gc[k]);
            c[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1]) | (p[4*k+2] & p[4*k+1] & g[4*k])
                     | ((&p[4*k +: 3]) & gc[k]);
        end
        sum_o = p ^ c;
    end

endmodule

// File: rtl/addsub_pipe32.sv
// Two-stage 32-bit add/sub: low 16-bit half in stage A, high half plus flags in stage B.
// Latency: result valid two rising edges after accept; one op per cycle when unstalled.
// Backpressure: stage B holds on !out_ready, A holds behind it; in_ready drops only when both are full.
module addsub_pipe32
    import alu_pkg::*;
#(
    parameter int TAG_W = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           flush,
    addsub_pipe32_if.slave io
);
    logic [XLEN-1:0]  bx;
    logic [HALF-1:0]  lo_sum;
    logic             lo_c16;
    logic [HALF-1:0]  hi_sum;
    logic             hi_c32;

    logic             a_valid_q, a_valid_d;
    logic             b_valid_q, b_valid_d;
    stage_a_t         a_q, a_d;
    result_t          b_q, b_d;
    logic [TAG_W-1:0] a_tag_q;
    logic [TAG_W-1:0] b_tag_q;

    logic             b_free;
    logic             a_adv;
    logic             accept;

    assign bx = cond_operand(io.in_b, io.in_op);

    // Low half evaluated directly on the incoming operands.
    cla16 u_cla_lo (
        .a_i    (io.in_a[HALF-1:0]),
        .b_i    (bx[HALF-1:0]),
        .cin_i  (io.in_op),
        .sum_o  (lo_sum),
        .cout_o (lo_c16)
    );

    // High half evaluated from stage A registers with the registered mid carry.
    cla16 u_cla_hi (
        .a_i    (a_q.hi_a),
        .b_i    (a_q.hi_bx),
        .cin_i  (a_q.c16),
        .sum_o  (hi_sum),
        .cout_o (hi_c32)
    );

    // in_ready looks through to out_ready so a draining pipe never bubbles.
    assign b_free      = !b_valid_q || io.out_ready;
    assign a_adv       = a_valid_q && b_free;
    assign io.in_ready = !a_valid_q || b_free;
    assign accept      = io.in_valid && io.in_ready && !flush;

    // Stage A next contents: finished low half, high operands carried forward.
    always_comb begin
        a_d         = a_q;
        a_d.lo_sum  = lo_sum;
        a_d.c16     = lo_c16;
        a_d.lo_zero = (lo_sum == '0);
        a_d.hi_a    = io.in_a[XLEN-1:HALF];
        a_d.hi_bx   = bx[XLEN-1:HALF];
    end

    // Stage B next contents: full sum and NZCV; overflow judged on the conditioned operand.
    always_comb begin
        b_d     = b_q;
        b_d.sum = {hi_sum, a_q.lo_sum};
        b_d.c   = hi_c32;
        b_d.z   = a_q.lo_zero && (hi_sum == '0);
        b_d.n   = hi_sum[HALF-1];
        b_d.v   = (a_q.hi_a[HALF-1] == a_q.hi_bx[HALF-1]) && (hi_sum[HALF-1] != a_q.hi_a[HALF-1]);
    end

    // Occupancy next-state; flush empties both stages ahead of any accept or advance.
    always_comb begin
        a_valid_d = a_valid_q;
        b_valid_d = b_valid_q;
        if (flush) begin
            a_valid_d = 1'b0;
            b_valid_d = 1'b0;
        end else begin
            if (a_adv) begin
                b_valid_d = 1'b1;
            end else if (io.out_ready) begin
                b_valid_d = 1'b0;
            end
            if (accept) begin
                a_valid_d = 1'b1;
            end else if (a_adv) begin
                a_valid_d = 1'b0;
            end
        end
    end

    // Occupancy registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_valid_q <= 1'b0;
            b_valid_q <= 1'b0;
        end else begin
            a_valid_q <= a_valid_d;
            b_valid_q <= b_valid_d;
        end
    end

    // Stage A data loads only on an accepted operation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q     <= '0;
            a_tag_q <= '0;
        end else if (accept) begin
            a_q     <= a_d;
            a_tag_q <= io.in_tag;
        end
    end

    // Stage B data loads only when stage A moves forward, so a stalled result stays put.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            b_q     <= '0;
            b_tag_q <= '0;
        end else if (a_adv && !flush) begin
            b_q     <= b_d;
            b_tag_q <= a_tag_q;
        end
    end

    assign io.out_valid = b_valid_q;
    assign io.out_sum   = b_q.sum;
    assign io.out_c     = b_q.c;
    assign io.out_z     = b_q.z;
    assign io.out_n     = b_q.n;
    assign io.out_v     = b_q.v;
    assign io.out_tag   = b_tag_q;

endmodule

// File: tb/tb_addsub_pipe32.sv
// Scoreboard bench for addsub_pipe32 using directed vectors with hand-worked results.
// Latency: checks the two-edge accept-to-valid timing on an idle pipe.
// Backpressure: stalls out_ready mid-stream and checks hold, in_ready and ordering.
module tb_addsub_pipe32;

    typedef struct packed {
        logic [31:0] sum;
        logic        c;
        logic        z;
        logic        n;
        logic        v;
        logic [3:0]  tag;
    } exp_t;

    logic clk;
    logic rst;
    logic flush;

    addsub_pipe32_if #(.TAG_W(4)) io ();

    addsub_pipe32 #(.TAG_W(4)) dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .io    (io)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int    n_cmp = 0;
    int    n_err = 0;
    exp_t  sb[$];

    logic        stalled   = 1'b0;
    logic [31:0] prev_sum  = '0;
    logic [3:0]  prev_tag  = '0;
    logic        saw_block = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: compares every retiring result against the head of the scoreboard.
    always @(negedge clk) begin
        exp_t got;
        exp_t e;
        if (rst || flush) begin
            stalled = 1'b0;
        end else begin
            if (stalled && io.out_valid) begin
                check("stall_hold_sum", 64'(io.out_sum), 64'(prev_sum));
                check("stall_hold_tag", 64'(io.out_tag), 64'(prev_tag));
            end
            if (io.out_valid && io.out_ready) begin
                got = '{io.out_sum, io.out_c, io.out_z, io.out_n, io.out_v, io.out_tag};
                if (sb.size() == 0) begin
                    check("spurious_out", 64'(io.out_valid), 64'd0);
                end else begin
                    e = sb.pop_front();
                    check($sformatf("result_tag%0d", e.tag), 64'(got), 64'(e));
                end
            end
            stalled  = io.out_valid && !io.out_ready;
            prev_sum = io.out_sum;
            prev_tag = io.out_tag;
        end
    end

    // Presents one op from #1 after a posedge; returns #1 after its accepting edge.
    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic op,
                         input logic [3:0] tag, input logic [31:0] sum,
                         input logic c, input logic z, input logic n, input logic v);
        int   cyc;
        exp_t e;
        io.in_valid = 1'b1;
        io.in_a     = a;
        io.in_b     = b;
        io.in_op    = op;
        io.in_tag   = tag;
        cyc = 0;
        forever begin
            @(negedge clk);
            if (io.in_ready && !flush) break;
            cyc++;
            if (cyc > 200) begin
                $display("FAIL issue_timeout: tag %0d never accepted", tag);
                $fatal(1, "accept timeout");
            end
        end
        e = '{sum, c, z, n, v, tag};
        sb.push_back(e);
        @(posedge clk);
        #1;
        io.in_valid = 1'b0;
    endtask

    task automatic wait_empty(input string name);
        int cyc;
        cyc = 0;
        while (sb.size() != 0 && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        check(name, 64'(sb.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst          = 1'b1;
        flush        = 1'b0;
        io.in_valid  = 1'b0;
        io.in_a      = '0;
        io.in_b      = '0;
        io.in_op     = 1'b0;
        io.in_tag    = '0;
        io.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 64'(io.out_valid), 64'd0);
        check("rst_in_ready",  64'(io.in_ready),  64'd1);
        check("rst_out_data",  64'({io.out_sum, io.out_c, io.out_z, io.out_n, io.out_v, io.out_tag}), 64'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Cross-half carry with latency check on an idle pipe.
        issue(32'h0000FFFF, 32'h00000001, 1'b0, 4'd1, 32'h00010000, 1'b0, 1'b0, 1'b0, 1'b0);
        check("lat_edge1_valid", 64'(io.out_valid), 64'd0);
        @(posedge clk);
        #1;
        check("lat_edge2_valid", 64'(io.out_valid), 64'd1);
        wait_empty("drain_carry");

        issue(32'h00000005, 32'h00000007, 1'b1, 4'd2, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b1, 1'b0);
        issue(32'h7FFFFFFF, 32'h00000001, 1'b0, 4'd3, 32'h80000000, 1'b0, 1'b0, 1'b1, 1'b1);
        issue(32'h80000000, 32'h00000001, 1'b1, 4'd4, 32'h7FFFFFFF, 1'b1, 1'b0, 1'b0, 1'b1);
        issue(32'h12345678, 32'h12345678, 1'b1, 4'd5, 32'h00000000, 1'b1, 1'b1, 1'b0, 1'b0);
        issue(32'hFFFFFFFF, 32'h00000001, 1'b0, 4'd6, 32'h00000000, 1'b1, 1'b1, 1'b0, 1'b0);
        issue(32'h00000000, 32'h00000000, 1'b1, 4'd7, 32'h00000000, 1'b1, 1'b1, 1'b0, 1'b0);
        wait_empty("drain_directed");

        // Back-to-back stream with out_ready low for cycles 3..6.
        saw_block = 1'b0;
        fork
            begin
                issue(32'h00000001, 32'h00000002, 1'b0, 4'd0, 32'h00000003, 1'b0, 1'b0, 1'b0, 1'b0);
                issue(32'h00000010, 32'h00000001, 1'b1, 4'd1, 32'h0000000F, 1'b1, 1'b0, 1'b0, 1'b0);
                issue(32'hFFFF0000, 32'h00010000, 1'b0, 4'd2, 32'h00000000, 1'b1, 1'b1, 1'b0, 1'b0);
                issue(32'h00000000, 32'h00000001, 1'b1, 4'd3, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b1, 1'b0);
                issue(32'h40000000, 32'h40000000, 1'b0, 4'd4, 32'h80000000, 1'b0, 1'b0, 1'b1, 1'b1);
                issue(32'h00010000, 32'h00000001, 1'b1, 4'd5, 32'h0000FFFF, 1'b1, 1'b0, 1'b0, 1'b0);
            end
            begin
                repeat (3) @(posedge clk);
                #1;
                io.out_ready = 1'b0;
                repeat (4) begin
                    @(negedge clk);
                    if (!io.in_ready) saw_block = 1'b1;
                    @(posedge clk);
                    #1;
                end
                io.out_ready = 1'b1;
            end
        join
        check("bp_in_ready_fell", 64'(saw_block), 64'd1);
        wait_empty("drain_stream");

        // Flush with both stages full and a new op presented.
        io.out_ready = 1'b0;
        issue(32'h00000100, 32'h00000200, 1'b0, 4'd8, 32'h00000300, 1'b0, 1'b0, 1'b0, 1'b0);
        issue(32'h00000300, 32'h00000400, 1'b0, 4'd9, 32'h00000700, 1'b0, 1'b0, 1'b0, 1'b0);
        check("flush_pre_full", 64'({io.out_valid, io.in_ready}), 64'b10);
        io.out_ready = 1'b1;
        io.in_valid  = 1'b1;
        io.in_a      = 32'h00000011;
        io.in_b      = 32'h00000022;
        io.in_op     = 1'b0;
        io.in_tag    = 4'd10;
        flush        = 1'b1;
        @(posedge clk);
        #1;
        flush       = 1'b0;
        io.in_valid = 1'b0;
        sb.delete();
        check("flush_out_valid", 64'(io.out_valid), 64'd0);
        check("flush_in_ready",  64'(io.in_ready),  64'd1);
        repeat (3) begin
            @(posedge clk);
            #1;
            check("flush_no_accept", 64'(io.out_valid), 64'd0);
        end

        // Asynchronous reset in the middle of a stalled pipe.
        io.out_ready = 1'b0;
        issue(32'h00000005, 32'h00000006, 1'b0, 4'd11, 32'h0000000B, 1'b0, 1'b0, 1'b0, 1'b0);
        issue(32'h00000007, 32'h00000008, 1'b0, 4'd12, 32'h0000000F, 1'b0, 1'b0, 1'b0, 1'b0);
        check("rst_pre_valid", 64'(io.out_valid), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        check("rst_async_valid",    64'(io.out_valid), 64'd0);
        check("rst_async_in_ready", 64'(io.in_ready),  64'd1);
        check("rst_async_data",     64'({io.out_sum, io.out_tag}), 64'd0);
        sb.delete();
        @(posedge clk);
        #1;
        rst          = 1'b0;
        io.out_ready = 1'b1;
        issue(32'h00000001, 32'h00000002, 1'b0, 4'd13, 32'h00000003, 1'b0, 1'b0, 1'b0, 1'b0);
        wait_empty("drain_after_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/addsub_pipe32.md
Name: addsub_pipe32

Overview:
- Two-stage pipelined 32-bit add/subtract execution stage with valid/ready handshakes on both sides and a tag passthrough.
- Sits between operand issue and writeback.
- Splits the 32-bit carry chain across two registered stages:
  - low 16-bit half in stage A;
  - high 16-bit half in stage B, using the registered carry from stage A.
- Each half is built from the team's existing CLA16 block, so the clock period covers one 16-bit lookahead instead of 32.

Parameters:
- TAG_W, 4, width of the opaque tag carried alongside each operation.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- flush  input  1  synchronous; discards all in-flight operations.
- in_valid  input  1  upstream holds a valid operation.
- in_ready  output  1  stage A can accept this cycle.
- in_a  input  32  operand A.
- in_b  input  32  operand B.
- in_op  input  1  0 = ADD, 1 = SUB (A − B).
- in_tag  input  TAG_W  returned unchanged with the result.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts the result.
- out_sum  output  32  result.
- out_c  output  1  carry out of bit 31 (for SUB: 1 = no borrow).
- out_z  output  1  out_sum == 0.
- out_n  output  1  out_sum[31].
- out_v  output  1  signed overflow.
- out_tag  output  TAG_W  tag of the result.

Behaviour:
- Reset (asynchronous, active-high):
  - a_valid and b_valid = 0; out_valid = 0.
  - out_sum, flags and out_tag = 0.
  - All internal data registers = 0.
- Operand conditioning (combinational on inputs):
  - bx = in_op ? ~in_b : in_b.
  - cin = in_op.
- Stage A load (on accept = in_valid && in_ready && !flush):
  - Low half: CLA16(in_a[15:0], bx[15:0], cin).
  - Registers: a_lo_sum[15:0], a_c16, a_lo_zero = (lo_sum == 0), a_hi_a = in_a[31:16], a_hi_bx = bx[31:16], a_tag.
  - a_valid = 1.
- Stage B load (on advance of stage A):
  - High half: CLA16(a_hi_a, a_hi_bx, a_c16) gives hi_sum and c32.
  - Registers:
    - out_sum = {hi_sum, a_lo_sum}.
    - out_c = c32.
    - out_z = a_lo_zero && (hi_sum == 0).
    - out_n = hi_sum[15].
    - out_v = (a_hi_a[15] == a_hi_bx[15]) && (hi_sum[15] != a_hi_a[15]).
    - out_tag = a_tag.
    - b_valid (= out_valid) = 1.
- Flow control:
  - b_free = !b_valid || out_ready.
  - a_adv = a_valid && b_free.
  - in_ready = !a_valid || b_free. This is combinational from out_ready, which is intentional and allowed.
- Valid updates:
  - b_valid next = a_adv ? 1 : (out_ready ? 0 : b_valid).
  - a_valid next = accept ? 1 : (a_adv ? 0 : a_valid).
- Latency and throughput:
  - Latency: out_valid asserts in the 2nd cycle after the accept edge, i.e. two rising edges.
  - Throughput: 1 operation per cycle while out_ready = 1.
- Stall: while out_valid && !out_ready, out_sum, flags and out_tag stay stable and stage A holds. in_ready = 0 only when both stages are full and stalled.
- Capacity: max 2 in flight. Results retire in accept order with no drop and no duplication.
- Flush:
  - Next edge: a_valid = 0 and b_valid = 0.
  - An operation presented in the flush cycle is not accepted.
  - flush has priority over accept and advance.
  - Data registers need not clear.
- Reset mid-operation: everything in flight is discarded immediately (asynchronous).
- Width rules:
  - Arithmetic is modulo 2^32.
  - out_c is the raw carry, not inverted for SUB.
  - 0 − 0: sum 0, C = 1, Z = 1.

Decomposition:
- Shared package alu_pkg:
  - OP_ADD = 1'b0, OP_SUB = 1'b1.
  - XLEN = 32, HALF = 16.
- Sub-module: two instances of the existing CLA16 block, one per stage.
- No new sub-module; pipeline control lives inline.

Test Plan:
- Cross-half carry: ADD 0x0000FFFF + 0x00000001, out_ready = 1.
  - Expect sum 0x00010000, C = 0, Z = 0, N = 0, V = 0.
  - out_valid exactly 2 edges after accept.
- Borrow: SUB 5 − 7.
  - Expect 0xFFFFFFFE, C = 0, N = 1, V = 0, Z = 0.
- Signed overflow:
  - ADD 0x7FFFFFFF + 1: expect 0x80000000, V = 1, N = 1, C = 0.
  - SUB 0x80000000 − 1: expect 0x7FFFFFFF, V = 1, C = 1.
- Equal operands: SUB 0x12345678 − 0x12345678.
  - Expect 0, Z = 1, C = 1.
  - ADD 0xFFFFFFFF + 1: expect 0, Z = 1, C = 1.
- Backpressure:
  - Stimulus: stream tags 0..5 back-to-back; drop out_ready for cycles 3–6.
  - in_ready falls once 2 operations are held.
  - out_sum/out_tag stay stable while stalled.
  - All 6 results emerge in order 0..5 with correct sums.
- Flush and reset:
  - Stimulus: flush with 2 in flight and in_valid = 1.
  - Next cycle: out_valid = 0, and the presented operation is not accepted.
  - Asserting rst mid-stream drops out_valid and in-flight state immediately.
  - After release, a fresh ADD 1 + 2 returns 3.
